// File: rtl/riscv_dmem_rsp_pkg.sv
// Shared definitions for the RV32I data-memory responder.
//   - FUNCT3_MEM_* : load/store funct3 codes, shared with the control path
//   - BYTE_SEL_*   : access-width codes carried on byte_sel
//   - DMEM_S_*     : responder FSM state encodings
//   - norm_byte_sel: folds any non-legal byte_sel code onto a full word
package riscv_dmem_rsp_pkg;

    localparam logic [2:0] FUNCT3_MEM_B  = 3'b000;
    localparam logic [2:0] FUNCT3_MEM_H  = 3'b001;
    localparam logic [2:0] FUNCT3_MEM_W  = 3'b010;
    localparam logic [2:0] FUNCT3_MEM_BU = 3'b100;
    localparam logic [2:0] FUNCT3_MEM_HU = 3'b101;

    localparam logic [3:0] BYTE_SEL_B = 4'b0001;
    localparam logic [3:0] BYTE_SEL_H = 4'b0011;
    localparam logic [3:0] BYTE_SEL_W = 4'b1111;

    localparam logic [1:0] DMEM_S_IDLE = 2'b00;
    localparam logic [1:0] DMEM_S_WAIT = 2'b01;
    localparam logic [1:0] DMEM_S_RESP = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = DMEM_S_IDLE,
        S_WAIT = DMEM_S_WAIT,
        S_RESP = DMEM_S_RESP
    } dmem_state_e;

    function automatic logic [3:0] norm_byte_sel(input logic [3:0] bs);
        if (bs == BYTE_SEL_B || bs == BYTE_SEL_H) begin
            return bs;
        end
        return BYTE_SEL_W;
    endfunction

endpackage

// File: rtl/riscv_dmem_rsp_if.sv
// Request/response channel between the core and the data-memory responder.
//   req_valid/req_ready : request handshake
//   wr_en, byte_sel, funct3, addr, wr_data : request payload
//   rsp_valid/rsp_ready : response handshake
//   rd_data, misalign   : response payload
// master = requester (core), slave = responder.
interface riscv_dmem_rsp_if;
    logic        req_valid;
    logic        req_ready;
    logic        wr_en;
    logic [3:0]  byte_sel;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rd_data;
    logic        misalign;

    modport master (
        output req_valid, wr_en, byte_sel, funct3, addr, wr_data, rsp_ready,
        input  req_ready, rsp_valid, rd_data, misalign
    );

    modport slave (
        input  req_valid, wr_en, byte_sel, funct3, addr, wr_data, rsp_ready,
        output req_ready, rsp_valid, rd_data, misalign
    );
endinterface

// File: rtl/riscv_dmem_lane.sv
// Combinational byte-lane steering for the data-memory responder.
//   byte_sel, funct3, offset : access width, signedness and byte offset in the word
//   wr_data                  : right-aligned store data
//   ram_word                 : current RAM word at the access index
//   wr_mask, wr_lane         : per-byte write enables and lane-aligned store data
//   rd_data                  : shifted and extended load data (0 when misaligned)
//   misalign                 : access crosses its natural alignment
module riscv_dmem_lane
    import riscv_dmem_rsp_pkg::*;
(
    input  logic [3:0]  byte_sel,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wr_data,
    input  logic [31:0] ram_word,
    output logic [3:0]  wr_mask,
    output logic [31:0] wr_lane,
    output logic [31:0] rd_data,
    output logic        misalign
);

    logic [3:0]  sel_n;
    logic [31:0] shifted;
    logic        is_unsigned;
    logic [1:0]  unused_funct3;

    assign sel_n         = norm_byte_sel(byte_sel);
    assign is_unsigned   = funct3[2];
    assign unused_funct3 = funct3[1:0];

    always_comb begin
        misalign = 1'b0;
        if (sel_n == BYTE_SEL_H && offset[0]) begin
            misalign = 1'b1;
        end
        if (sel_n == BYTE_SEL_W && offset != 2'b00) begin
            misalign = 1'b1;
        end
    end

    // Aligned accesses never shift bits out of the top, so plain truncation is safe.
    assign wr_mask = misalign ? 4'b0000 : (sel_n << offset);
    assign wr_lane = wr_data << {offset, 3'b000};
    assign shifted = ram_word >> {offset, 3'b000};

    always_comb begin
        rd_data = shifted;
        if (sel_n == BYTE_SEL_B) begin
            rd_data = is_unsigned ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        end else if (sel_n == BYTE_SEL_H) begin
            rd_data = is_unsigned ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        end
        if (misalign) begin
            rd_data = 32'd0;
        end
    end

endmodule

// File: rtl/riscv_dmem_rsp.sv
// Data-memory responder for the RV32I core: accepts load/store requests on a valid/ready
// channel, performs them on an internal word RAM after DMEM_LATENCY wait states and returns
// extended load data on a valid/ready response channel.
//   i_clk : clock
//   i_rst : synchronous active-high reset
//   dmem  : request/response channel (slave side)
module riscv_dmem_rsp
    import riscv_dmem_rsp_pkg::*;
#(
    parameter int unsigned DMEM_DEPTH   = 1024,
    parameter int unsigned DMEM_LATENCY = 1
) (
    input logic             i_clk,
    input logic             i_rst,
    riscv_dmem_rsp_if.slave dmem
);

    localparam int unsigned AW     = $clog2(DMEM_DEPTH);
    localparam logic [3:0]  LAT_M1 = (DMEM_LATENCY == 0) ? 4'd0 : 4'(DMEM_LATENCY - 1);

    dmem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        accept;
    logic        commit;

    logic          req_wr_q;
    logic [3:0]    req_bsel_q;
    logic [2:0]    req_f3_q;
    logic [AW+1:0] req_addr_q;
    logic [31:0]   req_wdata_q;

    logic          cur_wr;
    logic [3:0]    cur_bsel;
    logic [2:0]    cur_f3;
    logic [AW+1:0] cur_addr;
    logic [31:0]   cur_wdata;
    logic [AW-1:0] cur_idx;

    logic [31:0] mem [DMEM_DEPTH];
    logic [31:0] ram_word;
    logic [3:0]  wr_mask;
    logic [31:0] wr_lane;
    logic [31:0] lane_rd;
    logic        lane_mis;
    logic        mem_we;

    logic [31:0] rd_data_q;
    logic        misalign_q;
    logic [31:0] unused_addr;

    assign unused_addr = {dmem.addr[31:AW+2], {(AW + 2){1'b0}}};

    assign dmem.req_ready = (state_q == S_IDLE);
    assign dmem.rsp_valid = (state_q == S_RESP);
    assign dmem.rd_data   = rd_data_q;
    assign dmem.misalign  = misalign_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (dmem.req_valid) begin
                    accept = 1'b1;
                    if (DMEM_LATENCY == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (dmem.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // With zero latency the commit happens on the accepting edge, so the lane logic must see
    // the live request while idle and the latched one otherwise.
    always_comb begin
        if (state_q == S_IDLE) begin
            cur_wr    = dmem.wr_en;
            cur_bsel  = dmem.byte_sel;
            cur_f3    = dmem.funct3;
            cur_addr  = dmem.addr[AW+1:0];
            cur_wdata = dmem.wr_data;
        end else begin
            cur_wr    = req_wr_q;
            cur_bsel  = req_bsel_q;
            cur_f3    = req_f3_q;
            cur_addr  = req_addr_q;
            cur_wdata = req_wdata_q;
        end
    end

    assign cur_idx  = cur_addr[AW+1:2];
    assign ram_word = mem[cur_idx];
    assign mem_we   = commit && cur_wr && !lane_mis;

    riscv_dmem_lane u_lane (
        .byte_sel (cur_bsel),
        .funct3   (cur_f3),
        .offset   (cur_addr[1:0]),
        .wr_data  (cur_wdata),
        .ram_word (ram_word),
        .wr_mask  (wr_mask),
        .wr_lane  (wr_lane),
        .rd_data  (lane_rd),
        .misalign (lane_mis)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            rd_data_q  <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (commit) begin
                rd_data_q  <= cur_wr ? 32'd0 : lane_rd;
                misalign_q <= lane_mis;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && accept) begin
            req_wr_q    <= dmem.wr_en;
            req_bsel_q  <= dmem.byte_sel;
            req_f3_q    <= dmem.funct3;
            req_addr_q  <= dmem.addr[AW+1:0];
            req_wdata_q <= dmem.wr_data;
        end
    end

    // RAM is never reset; a reset arriving before commit simply suppresses the write.
    always_ff @(posedge i_clk) begin
        if (!i_rst && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) begin
                    mem[cur_idx][8*b +: 8] <= wr_lane[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_dmem_rsp.sv
// Self-checking bench for riscv_dmem_rsp: three instances (latency 1/depth 1024,
// latency 0/depth 16, latency 3/depth 16) share one stimulus port selected by 'sel'.
module tb_riscv_dmem_rsp;
    import riscv_dmem_rsp_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    int          sel;
    logic        t_req_valid, t_wr_en, t_rsp_ready;
    logic [3:0]  t_bsel;
    logic [2:0]  t_f3;
    logic [31:0] t_addr, t_wdata;

    logic        m_req_ready, m_rsp_valid, m_misalign;
    logic [31:0] m_rd_data;

    int n_cmp  = 0;
    int n_fail = 0;

    riscv_dmem_rsp_if if0 ();
    riscv_dmem_rsp_if if1 ();
    riscv_dmem_rsp_if if2 ();

    assign if0.req_valid = t_req_valid && (sel == 0);
    assign if1.req_valid = t_req_valid && (sel == 1);
    assign if2.req_valid = t_req_valid && (sel == 2);
    assign if0.rsp_ready = t_rsp_ready && (sel == 0);
    assign if1.rsp_ready = t_rsp_ready && (sel == 1);
    assign if2.rsp_ready = t_rsp_ready && (sel == 2);
    assign if0.wr_en = t_wr_en;  assign if1.wr_en = t_wr_en;  assign if2.wr_en = t_wr_en;
    assign if0.byte_sel = t_bsel; assign if1.byte_sel = t_bsel; assign if2.byte_sel = t_bsel;
    assign if0.funct3 = t_f3;    assign if1.funct3 = t_f3;    assign if2.funct3 = t_f3;
    assign if0.addr = t_addr;    assign if1.addr = t_addr;    assign if2.addr = t_addr;
    assign if0.wr_data = t_wdata; assign if1.wr_data = t_wdata; assign if2.wr_data = t_wdata;

    always_comb begin
        m_req_ready = if0.req_ready;
        m_rsp_valid = if0.rsp_valid;
        m_rd_data   = if0.rd_data;
        m_misalign  = if0.misalign;
        if (sel == 1) begin
            m_req_ready = if1.req_ready;
            m_rsp_valid = if1.rsp_valid;
            m_rd_data   = if1.rd_data;
            m_misalign  = if1.misalign;
        end else if (sel == 2) begin
            m_req_ready = if2.req_ready;
            m_rsp_valid = if2.rsp_valid;
            m_rd_data   = if2.rd_data;
            m_misalign  = if2.misalign;
        end
    end

    riscv_dmem_rsp #(.DMEM_DEPTH(1024), .DMEM_LATENCY(1)) u_dut0 (
        .i_clk (clk), .i_rst (rst), .dmem (if0.slave)
    );
    riscv_dmem_rsp #(.DMEM_DEPTH(16), .DMEM_LATENCY(0)) u_dut1 (
        .i_clk (clk), .i_rst (rst), .dmem (if1.slave)
    );
    riscv_dmem_rsp #(.DMEM_DEPTH(16), .DMEM_LATENCY(3)) u_dut2 (
        .i_clk (clk), .i_rst (rst), .dmem (if2.slave)
    );

    typedef struct {
        int          s;
        logic        wr;
        logic [3:0]  bs;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int s, input logic wr, input logic [3:0] bs, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_mis);
        vec_t v;
        v.s = s; v.wr = wr; v.bs = bs; v.f3 = f3; v.addr = addr; v.wd = wd;
        v.exp_rd = exp_rd; v.exp_mis = exp_mis;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input int s);
        if (s == 1) return 1;
        if (s == 2) return 4;
        return 2;
    endfunction

    // Entered and left just after a falling edge.
    task automatic do_req(input int s, input logic wr, input logic [3:0] bs, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic mis, output int lat);
        int n;
        sel = s; t_wr_en = wr; t_bsel = bs; t_f3 = f3; t_addr = a; t_wdata = wd;
        t_req_valid = 1'b1;
        rd = 32'd0; mis = 1'b0; lat = -1;
        n = 0;
        while (!m_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!m_req_ready) begin
            chk("req_ready timeout", {31'd0, m_req_ready}, 32'd1);
            t_req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        t_req_valid = 1'b0;
        lat = 1;
        while (!m_rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!m_rsp_valid) begin
            chk("rsp_valid timeout", {31'd0, m_rsp_valid}, 32'd1);
            return;
        end
        rd  = m_rd_data;
        mis = m_misalign;
        t_rsp_ready = 1'b1;
        @(negedge clk);
        t_rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        mis;
        int          lat;
        int          n;

        rst = 1'b1; sel = 0; t_req_valid = 1'b0; t_rsp_ready = 1'b0; t_wr_en = 1'b0;
        t_bsel = BYTE_SEL_W; t_f3 = FUNCT3_MEM_W; t_addr = 32'd0; t_wdata = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk($sformatf("reset%0d req_ready", s), {31'd0, m_req_ready}, 32'd1);
            chk($sformatf("reset%0d rsp_valid", s), {31'd0, m_rsp_valid}, 32'd0);
            chk($sformatf("reset%0d rd_data", s), m_rd_data, 32'd0);
            chk($sformatf("reset%0d misalign", s), {31'd0, m_misalign}, 32'd0);
        end
        @(negedge clk);

        //   s  wr  byte_sel    funct3        addr           wr_data        rd_data        mis
        add(0, 1, BYTE_SEL_W, FUNCT3_MEM_W,  32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 0);
        add(0, 0, BYTE_SEL_W, FUNCT3_MEM_W,  32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0);
        add(0, 1, BYTE_SEL_W, FUNCT3_MEM_W,  32'h0000_0010, 32'h0,         32'h0000_0000, 0);
        add(0, 1, BYTE_SEL_B, FUNCT3_MEM_B,  32'h0000_0013, 32'h0000_0080, 32'h0000_0000, 0);
        add(0, 0, BYTE_SEL_B, FUNCT3_MEM_B,  32'h0000_0013, 32'h0,         32'hFFFF_FF80, 0);
        add(0, 0, BYTE_SEL_B, FUNCT3_MEM_BU, 32'h0000_0013, 32'h0,         32'h0000_0080, 0);
        add(0, 0, BYTE_SEL_W, FUNCT3_MEM_W,  32'h0000_0010, 32'h0,         32'h8000_0000, 0);
        add(0, 0, BYTE_SEL_H, FUNCT3_MEM_H,  32'h0000_0012, 32'h0,         32'hFFFF_8000, 0);
        add(0, 0, BYTE_SEL_H, FUNCT3_MEM_HU, 32'h0000_0012, 32'h0,         32'h0000_8000, 0);
        add(0, 0, 4'b0101,    FUNCT3_MEM_W,  32'h0000_0010, 32'h0,         32'h8000_0000, 0);
        add(0, 0, BYTE_SEL_W, FUNCT3_MEM_W,  32'h0000_1010, 32'h0,         32'h8000_0000, 0);
        add(0, 1, BYTE_SEL_W, FUNCT3_MEM_W,  32'h0000_0020, 32'h0,         32'h0000_0000, 0);
        add(0, 1, BYTE_SEL_H, FUNCT3_MEM_H,  32'h0000_0022, 32'h0000_8001, 32'h0000_0000, 0);
        add(0, 0, BYTE_SEL_H, FUNCT3_MEM_H,  32'h0000_0022, 32'h0,         32'hFFFF_8001, 0);
        add(0, 0, BYTE_SEL_H, FUNCT3_MEM_HU, 32'h0000_0022, 32'h0,         32'h0000_8001, 0);
        add(0, 0, BYTE_SEL_H, FUNCT3_MEM_H,  32'h0000_0021, 32'h0,         32'h0000_0000, 1);
        add(0, 0, BYTE_SEL_W, FUNCT3_MEM_W,  32'h0000_0020, 32'h0,         32'h8001_0000, 0);
        add(0, 1, BYTE_SEL_W, FUNCT3_MEM_W,  32'h0000_0030, 32'h1234_5678, 32'h0000_0000, 0);
        add(0, 1, BYTE_SEL_W, FUNCT3_MEM_W,  32'h0000_0031, 32'hAAAA_AAAA, 32'h0000_0000, 1);
        add(0, 0, BYTE_SEL_W, FUNCT3_MEM_W,  32'h0000_0030, 32'h0,         32'h1234_5678, 0);
        add(0, 0, BYTE_SEL_W, FUNCT3_MEM_W,  32'h0000_0032, 32'h0,         32'h0000_0000, 1);
        add(0, 1, BYTE_SEL_H, FUNCT3_MEM_H,  32'h0000_0033, 32'h0000_FFFF, 32'h0000_0000, 1);
        add(0, 0, BYTE_SEL_W, FUNCT3_MEM_W,  32'h0000_0030, 32'h0,         32'h1234_5678, 0);
        add(0, 1, BYTE_SEL_B, FUNCT3_MEM_B,  32'h0000_0031, 32'hFFFF_FF99, 32'h0000_0000, 0);
        add(0, 0, BYTE_SEL_W, FUNCT3_MEM_W,  32'h0000_0030, 32'h0,         32'h1234_9978, 0);
        add(1, 1, BYTE_SEL_W, FUNCT3_MEM_W,  32'h0000_0004, 32'h1122_3344, 32'h0000_0000, 0);
        add(1, 0, BYTE_SEL_W, FUNCT3_MEM_W,  32'h0000_0044, 32'h0,         32'h1122_3344, 0);
        add(1, 0, BYTE_SEL_B, FUNCT3_MEM_BU, 32'h0000_0045, 32'h0,         32'h0000_0033, 0);
        add(1, 0, BYTE_SEL_B, FUNCT3_MEM_B,  32'h0000_0006, 32'h0,         32'h0000_0022, 0);
        add(1, 1, BYTE_SEL_H, FUNCT3_MEM_H,  32'h0000_007E, 32'h0000_BEEF, 32'h0000_0000, 0);
        add(1, 0, BYTE_SEL_H, FUNCT3_MEM_H,  32'h0000_003E, 32'h0,         32'hFFFF_BEEF, 0);
        add(2, 1, BYTE_SEL_W, FUNCT3_MEM_W,  32'h0000_003C, 32'hCAFE_F00D, 32'h0000_0000, 0);
        add(2, 0, BYTE_SEL_W, FUNCT3_MEM_W,  32'h0000_007C, 32'h0,         32'hCAFE_F00D, 0);
        add(2, 0, BYTE_SEL_H, FUNCT3_MEM_H,  32'h0000_003E, 32'h0,         32'hFFFF_CAFE, 0);
        add(2, 0, BYTE_SEL_H, FUNCT3_MEM_HU, 32'h0000_003E, 32'h0,         32'h0000_CAFE, 0);
        add(2, 0, BYTE_SEL_B, FUNCT3_MEM_B,  32'h0000_003C, 32'h0,         32'h0000_000D, 0);
        add(2, 1, BYTE_SEL_W, FUNCT3_MEM_W,  32'h0000_0014, 32'h5555_5555, 32'h0000_0000, 0);

        foreach (vecs[i]) begin
            do_req(vecs[i].s, vecs[i].wr, vecs[i].bs, vecs[i].f3, vecs[i].addr, vecs[i].wd,
                   rd, mis, lat);
            chk($sformatf("vec%0d rd_data", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d misalign", i), {31'd0, mis}, {31'd0, vecs[i].exp_mis});
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(exp_lat(vecs[i].s)));
        end

        // Backpressure: response held for 5 cycles while a second request is offered.
        sel = 0; t_wr_en = 1'b0; t_bsel = BYTE_SEL_W; t_f3 = FUNCT3_MEM_W; t_addr = 32'h10;
        t_req_valid = 1'b1;
        @(negedge clk);
        t_req_valid = 1'b0;
        n = 0;
        while (!m_rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d rsp_valid", k), {31'd0, m_rsp_valid}, 32'd1);
            chk($sformatf("bp%0d rd_data", k), m_rd_data, 32'h8000_0000);
            chk($sformatf("bp%0d misalign", k), {31'd0, m_misalign}, 32'd0);
            chk($sformatf("bp%0d req_ready", k), {31'd0, m_req_ready}, 32'd0);
            t_wr_en = 1'b1; t_wdata = 32'hFFFF_FFFF;
            t_req_valid = (k < 4);
            if (k < 4) @(negedge clk);
        end
        t_wr_en = 1'b0;
        t_rsp_ready = 1'b1;
        @(negedge clk);
        t_rsp_ready = 1'b0;
        chk("bp after handshake req_ready", {31'd0, m_req_ready}, 32'd1);
        do_req(0, 1'b0, BYTE_SEL_W, FUNCT3_MEM_W, 32'h10, 32'h0, rd, mis, lat);
        chk("bp ignored store", rd, 32'h8000_0000);

        // Reset mid-wait aborts a pending store to word 5 of the latency-3 instance.
        sel = 2; t_wr_en = 1'b1; t_bsel = BYTE_SEL_W; t_f3 = FUNCT3_MEM_W;
        t_addr = 32'h14; t_wdata = 32'hA5A5_A5A5; t_req_valid = 1'b1;
        @(negedge clk);
        t_req_valid = 1'b0;
        chk("abort in wait req_ready", {31'd0, m_req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("abort rst%0d rsp_valid", k), {31'd0, m_rsp_valid}, 32'd0);
            chk($sformatf("abort rst%0d req_ready", k), {31'd0, m_req_ready}, 32'd1);
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("abort post%0d rsp_valid", k), {31'd0, m_rsp_valid}, 32'd0);
            chk($sformatf("abort post%0d req_ready", k), {31'd0, m_req_ready}, 32'd1);
        end
        do_req(2, 1'b0, BYTE_SEL_W, FUNCT3_MEM_W, 32'h14, 32'h0, rd, mis, lat);
        chk("abort word5 old contents", rd, 32'h5555_5555);
        chk("abort load latency", 32'(lat), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
